// File: rtl/dm_arbiter_pkg.sv
// Shared state encoding, default widths and tie-break helper for the
// two-master data-memory arbiter.
package dm_arbiter_pkg;

    localparam int DM_AW    = 32;
    localparam int DM_DW    = 32;
    localparam int DM_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2
    } arb_state_e;

    // On a tie the master that was not served most recently wins (last=1 favours m0).
    function automatic logic pick_m1(input logic req0, input logic req1, input logic last);
        return req1 && (!req0 || !last);
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Request/acknowledge bundle between one memory master and the arbiter.
interface dm_arbiter_if
    import dm_arbiter_pkg::*;
#(
    parameter int AW = DM_AW,
    parameter int DW = DM_DW
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/dm_arbiter_satcnt.sv
// Saturating up-counter with asynchronous active-low clear.
module dm_arbiter_satcnt
    import dm_arbiter_pkg::*;
#(
    parameter int CNT_W = DM_CNT_W
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Increment unless already at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !(&cnt_q)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU
// load/store path (m0) and the debug/loader port (m1); one access per grant.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int AW    = DM_AW,
    parameter int DW    = DM_DW,
    parameter int CNT_W = DM_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    dm_arbiter_if.slave      m0,
    dm_arbiter_if.slave      m1,
    output logic             MemWrite,
    output logic [AW-1:0]    pc_alu,
    output logic [DW-1:0]    data_rt,
    input  logic [DW-1:0]    data_out,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    arb_state_e    state_q;
    arb_state_e    state_d;
    logic          last_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    // Next grant; the master in its own ack cycle is ignored so it cannot be served twice in a row.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (m0.req || m1.req) begin
                    state_d = pick_m1(m0.req, m1.req, last_q) ? ST_ACC1 : ST_ACC0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACC0: state_d = m1.req ? ST_ACC1 : ST_IDLE;
            ST_ACC1: state_d = m0.req ? ST_ACC0 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant FSM, last-served flag and registered load data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            last_q   <= 1'b1;
            rdata0_q <= {DW{1'b0}};
            rdata1_q <= {DW{1'b0}};
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_ACC0: begin
                    last_q <= 1'b0;
                    if (!m0.we) rdata0_q <= data_out;
                end
                ST_ACC1: begin
                    last_q <= 1'b1;
                    if (!m1.we) rdata1_q <= data_out;
                end
                default: ;
            endcase
        end
    end

    // Memory pins and acks are pure state decode, so reset silences them immediately.
    always_comb begin
        MemWrite = 1'b0;
        pc_alu   = {AW{1'b0}};
        data_rt  = {DW{1'b0}};
        m0.ack   = 1'b0;
        m1.ack   = 1'b0;
        case (state_q)
            ST_ACC0: begin
                MemWrite = m0.we;
                pc_alu   = m0.addr;
                data_rt  = m0.wdata;
                m0.ack   = 1'b1;
            end
            ST_ACC1: begin
                MemWrite = m1.we;
                pc_alu   = m1.addr;
                data_rt  = m1.wdata;
                m1.ack   = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign m0.rdata = rdata0_q;
    assign m1.rdata = rdata1_q;

    dm_arbiter_satcnt #(.CNT_W(CNT_W)) u_cnt0 (
        .clk   (clk),
        .clr_n (reset),
        .inc_i (state_q == ST_ACC0),
        .cnt_o (cnt0)
    );

    dm_arbiter_satcnt #(.CNT_W(CNT_W)) u_cnt1 (
        .clk   (clk),
        .clr_n (reset),
        .inc_i (state_q == ST_ACC1),
        .cnt_o (cnt1)
    );

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed plus randomized bench for dm_arbiter against a transaction-level
// model of round-robin service, a reference memory and saturating counts.
module tb_dm_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          MemWrite;
    logic [AW-1:0] pc_alu;
    logic [DW-1:0] data_rt;
    logic [DW-1:0] data_out;
    logic          busy;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;

    dm_arbiter_if #(.AW(AW), .DW(DW)) m0if ();
    dm_arbiter_if #(.AW(AW), .DW(DW)) m1if ();

    dm_arbiter #(.AW(AW), .DW(DW), .CNT_W(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .m0       (m0if),
        .m1       (m1if),
        .MemWrite (MemWrite),
        .pc_alu   (pc_alu),
        .data_rt  (data_rt),
        .data_out (data_out),
        .busy     (busy),
        .cnt0     (cnt0),
        .cnt1     (cnt1)
    );

    always #5 clk = ~clk;

    // Data memory seen by the DUT: combinational read, write on the clock edge.
    logic [31:0] dm_mem [0:63] = '{default: 32'h0};
    assign data_out = dm_mem[pc_alu[7:2]];
    always @(posedge clk) if (MemWrite) dm_mem[pc_alu[7:2]] <= data_rt;

    // Reference state.
    logic [31:0] ref_mem [0:63];
    logic [31:0] exp_rd [2];
    int          cexp [2];
    int          served;
    int          last;
    int          n_err = 0;
    int          n_chk = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic set_m(input int n, input logic rq, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (n == 0) begin
            m0if.req = rq; m0if.we = w; m0if.addr = a; m0if.wdata = d;
        end else begin
            m1if.req = rq; m1if.we = w; m1if.addr = a; m1if.wdata = d;
        end
    endtask

    function automatic logic req_of(input int n);
        return (n == 0) ? m0if.req : m1if.req;
    endfunction

    task automatic rand_cmd(input int n);
        set_m(n, 1'b1, 1'($urandom_range(0, 1)), {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom());
    endtask

    task automatic model_reset();
        served = -1;
        last   = 1;
        exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
        cexp[0] = 0; cexp[1] = 0;
    endtask

    // Who is served next: a requesting master that was not served in the
    // current cycle; if both qualify, the one other than the last served.
    function automatic int predict();
        logic e0, e1;
        e0 = m0if.req && (served != 0);
        e1 = m1if.req && (served != 1);
        if (e0 && e1) return (last == 1) ? 0 : 1;
        else if (e0) return 0;
        else if (e1) return 1;
        else return -1;
    endfunction

    task automatic serve(input int n, input logic w, input logic [31:0] a, input logic [31:0] d);
        last = n;
        if (w) ref_mem[a[7:2]] = d;
        else   exp_rd[n] = ref_mem[a[7:2]];
        if (cexp[n] < CMAX) cexp[n]++;
    endtask

    // One clock: check state accumulated so far, then the current cycle's pins.
    task automatic step();
        int g;
        logic [31:0] e_we, e_addr, e_data;
        g = predict();
        @(posedge clk);
        #1;
        chk("rdata0", m0if.rdata, exp_rd[0]);
        chk("rdata1", m1if.rdata, exp_rd[1]);
        chk("cnt0", 32'(cnt0), 32'(cexp[0]));
        chk("cnt1", 32'(cnt1), 32'(cexp[1]));
        e_we = 32'h0; e_addr = 32'h0; e_data = 32'h0;
        if (g == 0) begin
            e_we = 32'(m0if.we); e_addr = m0if.addr; e_data = m0if.wdata;
            serve(0, m0if.we, m0if.addr, m0if.wdata);
        end else if (g == 1) begin
            e_we = 32'(m1if.we); e_addr = m1if.addr; e_data = m1if.wdata;
            serve(1, m1if.we, m1if.addr, m1if.wdata);
        end
        served = g;
        chk("ack0", 32'(m0if.ack), 32'(g == 0));
        chk("ack1", 32'(m1if.ack), 32'(g == 1));
        chk("busy", 32'(busy), 32'(g != -1));
        chk("MemWrite", 32'(MemWrite), e_we);
        chk("pc_alu", pc_alu, e_addr);
        chk("data_rt", data_rt, e_data);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_MemWrite"}, 32'(MemWrite), 32'h0);
        chk({tag, "_pc_alu"}, pc_alu, 32'h0);
        chk({tag, "_data_rt"}, data_rt, 32'h0);
        chk({tag, "_ack0"}, 32'(m0if.ack), 32'h0);
        chk({tag, "_ack1"}, 32'(m1if.ack), 32'h0);
        chk({tag, "_rdata0"}, m0if.rdata, 32'h0);
        chk({tag, "_rdata1"}, m1if.rdata, 32'h0);
        chk({tag, "_cnt0"}, 32'(cnt0), 32'h0);
        chk({tag, "_cnt1"}, 32'(cnt1), 32'h0);
    endtask

    // Reset pulse from an idle point between clock edges.
    task automatic do_reset();
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        #2;
        check_idle("rst");
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        int pg;
        logic [31:0] saved;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        model_reset();
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset held, then released at 30ns with no requests.
        #28;
        check_idle("t1_in_reset");
        #2;
        reset = 1'b1;
        #1;
        check_idle("t1_released");

        // m0 store then load of the same word.
        set_m(0, 1'b1, 1'b1, 32'h10, 32'h1111);
        step();
        chk("t2_store_we", 32'(MemWrite), 32'h1);
        step();
        set_m(0, 1'b1, 1'b0, 32'h10, 32'h0);
        step();
        chk("t2_load_ack", 32'(m0if.ack), 32'h1);
        chk("t2_load_we", 32'(MemWrite), 32'h0);
        step();
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("t2_rdata", m0if.rdata, 32'h0000_1111);

        // Simultaneous m1 store / m0 load; m0 served last so m1 goes first.
        set_m(1, 1'b1, 1'b1, 32'h20, 32'hABCD);
        set_m(0, 1'b1, 1'b0, 32'h20, 32'h0);
        step();
        chk("t4_m1_first", 32'(m1if.ack), 32'h1);
        step();
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("t4_m0_second", 32'(m0if.ack), 32'h1);
        step();
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("t4_rdata", m0if.rdata, 32'h0000_ABCD);

        // Fresh reset, both request together: grants alternate 0,1,0,1.
        do_reset();
        set_m(0, 1'b1, 1'b1, 32'h40, 32'hA0A0_0001);
        set_m(1, 1'b1, 1'b1, 32'h44, 32'hB0B0_0001);
        step();
        chk("t3_g1", 32'(m0if.ack), 32'h1);
        step();
        chk("t3_g2", 32'(m1if.ack), 32'h1);
        set_m(0, 1'b1, 1'b0, 32'h44, 32'h0);
        step();
        chk("t3_g3", 32'(m0if.ack), 32'h1);
        set_m(1, 1'b1, 1'b0, 32'h40, 32'h0);
        step();
        chk("t3_g4", 32'(m1if.ack), 32'h1);
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("t3_cnt0", 32'(cnt0), 32'h2);
        chk("t3_cnt1", 32'(cnt1), 32'h2);
        chk("t3_rdata0", m0if.rdata, 32'hB0B0_0001);
        chk("t3_rdata1", m1if.rdata, 32'hA0A0_0001);

        // Randomized traffic from both masters under the handshake rules.
        for (int k = 0; k < 400; k++) begin
            pg = served;
            step();
            for (int n = 0; n < 2; n++) begin
                if (n == pg) begin
                    if ($urandom_range(0, 3) == 0) set_m(n, 1'b0, 1'b0, 32'h0, 32'h0);
                    else rand_cmd(n);
                end else if (n != served && !req_of(n)) begin
                    if ($urandom_range(0, 2) == 0) rand_cmd(n);
                end
            end
        end
        for (int k = 0; k < 8; k++) begin
            if (m0if.req || m1if.req || served != -1) begin
                pg = served;
                step();
                if (pg == 0) set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
                if (pg == 1) set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        chk("drain_idle", 32'(served), 32'hFFFF_FFFF);

        // Reset in the middle of an m1 store: pins drop at once, no ack, write lost.
        do_reset();
        saved = ref_mem[12];
        set_m(1, 1'b1, 1'b1, 32'h30, 32'h5555_AAAA);
        step();
        #2;
        reset = 1'b0;
        #1;
        chk("t5_MemWrite", 32'(MemWrite), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_ack1", 32'(m1if.ack), 32'h0);
        chk("t5_pc_alu", pc_alu, 32'h0);
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
        ref_mem[12] = saved;
        model_reset();
        reset = 1'b1;
        step();

        // 17 m0 accesses saturate the 4-bit counter; m1 still counts afterwards.
        for (int k = 0; k < 17; k++) begin
            set_m(0, 1'b1, 1'(k % 2), {26'h0, k[3:0], 2'b00}, $urandom());
            step();
            step();
            if (k == 14) chk("t6_cnt0_at_15", 32'(cnt0), 32'hF);
        end
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk("t6_cnt0_sat", 32'(cnt0), 32'hF);
        chk("t6_cnt1_zero", 32'(cnt1), 32'h0);
        set_m(1, 1'b1, 1'b1, 32'h3C, 32'h0BAD_F00D);
        step();
        step();
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("t6_cnt1_inc", 32'(cnt1), 32'h1);
        chk("t6_cnt0_hold", 32'(cnt0), 32'hF);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
